fetch_stage: RTL and testbench

//  Instruction-fetch stage of the pipelined MIPS32 core; the producer end of the main decoder's

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : MIPS32 instruction fetch: PC register, redirect select, IF/ID
//               pipeline register and accepted-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        pc_src_br,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [5:0]  opcode_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_count;

  logic        w_redirect;
  logic        w_redirect_taken;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_redirect       = jr | jump | pc_src_br;
  assign w_redirect_taken = w_redirect & ~stall_f;
  assign w_pc_plus4       = r_pc + 32'd4;

  // jr outranks jump outranks branch; only matters if ID ever overlaps them
  always_comb begin
    w_target = br_target;
    if (jr) begin
      w_target = jr_target;
    end else if (jump) begin
      w_target = jump_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (!stall_f) begin
      r_pc <= w_redirect ? w_target : w_pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'd0;
      r_valid    <= 1'b0;
      r_count    <= 32'd0;
    end else if (!stall_d) begin
      if (w_redirect_taken) begin
        // wrong-path word in fetch is squashed into a bubble
        r_instr    <= NOP_INSTR;
        r_pc_plus4 <= 32'd0;
        r_valid    <= 1'b0;
      end else begin
        r_instr    <= imem_rdata;
        r_pc_plus4 <= w_pc_plus4;
        r_valid    <= 1'b1;
        r_count    <= r_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_redirect_taken) begin
          w_state_next = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (!stall_f) begin
          w_state_next = w_redirect ? ST_REDIR : ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign imem_addr   = r_pc;
  assign pc_f        = r_pc;
  assign instr_d     = r_instr;
  assign opcode_d    = r_instr[31:26];
  assign pc_plus4_d  = r_pc_plus4;
  assign valid_d     = r_valid;
  assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        stall_d;
  logic        pc_src_br;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [5:0]  opcode_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] fetch_count;

  // second instance placed near the top of the address space for wrap checks
  logic [31:0] w_imem_addr2;
  logic [31:0] w_imem_rdata2;
  logic [31:0] w_pc_f2;
  logic [31:0] w_instr_d2;
  logic [5:0]  w_opcode_d2;
  logic [31:0] w_pc_plus4_d2;
  logic        w_valid_d2;
  logic [31:0] w_fetch_count2;

  int errors;
  int checks;

  // instruction memory: opcode field carries addr[7:2], low 26 bits carry the address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[7:2], a[25:0]};
  endfunction

  assign imem_rdata    = word_at(imem_addr);
  assign w_imem_rdata2 = word_at(w_imem_addr2);

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
    .pc_src_br(pc_src_br), .br_target(br_target), .jump(jump),
    .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_f(pc_f),
    .instr_d(instr_d), .opcode_d(opcode_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_wrap (
    .clk(clk), .rst(rst), .stall_f(1'b0), .stall_d(1'b0),
    .pc_src_br(1'b0), .br_target(32'd0), .jump(1'b0),
    .jump_target(32'd0), .jr(1'b0), .jr_target(32'd0),
    .imem_addr(w_imem_addr2), .imem_rdata(w_imem_rdata2), .pc_f(w_pc_f2),
    .instr_d(w_instr_d2), .opcode_d(w_opcode_d2), .pc_plus4_d(w_pc_plus4_d2),
    .valid_d(w_valid_d2), .fetch_count(w_fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_f = 0; stall_d = 0; pc_src_br = 0; br_target = 0;
    jump = 0; jump_target = 0; jr = 0; jr_target = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_f, 32'h0); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", instr_d, 32'h0); end
    checks++; if (pc_plus4_d !== 32'h0) begin errors++; $display("FAIL reset_pcp4 got=%h exp=%h", pc_plus4_d, 32'h0); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, 32'h0); end
    rst = 0;
  endtask

  task automatic test_free_run();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (pc_f !== 32'(4 * k)) begin errors++; $display("FAIL run_pc[%0d] got=%h exp=%h", k, pc_f, 32'(4 * k)); end
      checks++; if (instr_d !== word_at(32'(4 * (k - 1)))) begin errors++; $display("FAIL run_instr[%0d] got=%h exp=%h", k, instr_d, word_at(32'(4 * (k - 1)))); end
      checks++; if (pc_plus4_d !== 32'(4 * k)) begin errors++; $display("FAIL run_pcp4[%0d] got=%h exp=%h", k, pc_plus4_d, 32'(4 * k)); end
      checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL run_valid[%0d] got=%b exp=1", k, valid_d); end
      checks++; if (fetch_count !== 32'(k)) begin errors++; $display("FAIL run_count[%0d] got=%0d exp=%0d", k, fetch_count, k); end
    end
  endtask

  task automatic test_jump();
    do_reset();
    step(); step(); step();
    checks++; if (pc_f !== 32'h0C) begin errors++; $display("FAIL jump_pre_pc got=%h exp=%h", pc_f, 32'h0C); end
    jump = 1; jump_target = 32'h40;
    step();
    jump = 0;
    checks++; if (pc_f !== 32'h40) begin errors++; $display("FAIL jump_pc got=%h exp=%h", pc_f, 32'h40); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL jump_bubble_instr got=%h exp=%h", instr_d, 32'h0); end
    checks++; if (pc_plus4_d !== 32'h0) begin errors++; $display("FAIL jump_bubble_pcp4 got=%h exp=%h", pc_plus4_d, 32'h0); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL jump_bubble_valid got=%b exp=0", valid_d); end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL jump_bubble_count got=%0d exp=3", fetch_count); end
    step();
    checks++; if (pc_f !== 32'h44) begin errors++; $display("FAIL jump_next_pc got=%h exp=%h", pc_f, 32'h44); end
    checks++; if (instr_d !== 32'h4000_0040) begin errors++; $display("FAIL jump_target_instr got=%h exp=%h", instr_d, 32'h4000_0040); end
    checks++; if (opcode_d !== 6'h10) begin errors++; $display("FAIL jump_opcode got=%h exp=%h", opcode_d, 6'h10); end
    checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL jump_target_valid got=%b exp=1", valid_d); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL jump_target_count got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    stall_f = 1; stall_d = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (pc_f !== 32'h08) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=%h", k, pc_f, 32'h08); end
      checks++; if (instr_d !== word_at(32'h04)) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=%h", k, instr_d, word_at(32'h04)); end
      checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, valid_d); end
      checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d] got=%0d exp=2", k, fetch_count); end
    end
    stall_f = 0; stall_d = 0;
    step();
    checks++; if (pc_f !== 32'h0C) begin errors++; $display("FAIL stall_resume_pc got=%h exp=%h", pc_f, 32'h0C); end
    checks++; if (instr_d !== word_at(32'h08)) begin errors++; $display("FAIL stall_resume_instr got=%h exp=%h", instr_d, word_at(32'h08)); end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL stall_resume_count got=%0d exp=3", fetch_count); end
  endtask

  task automatic test_branch_stalled();
    do_reset();
    step(); step();
    // stall_f alone: redirect ignored, IF/ID reloads the held word and counts it
    pc_src_br = 1; br_target = 32'h80; stall_f = 1;
    step();
    checks++; if (pc_f !== 32'h08) begin errors++; $display("FAIL brst_pc got=%h exp=%h", pc_f, 32'h08); end
    checks++; if (instr_d !== word_at(32'h08)) begin errors++; $display("FAIL brst_instr got=%h exp=%h", instr_d, word_at(32'h08)); end
    checks++; if (valid_d !== 1'b1) begin errors++; $display("FAIL brst_valid got=%b exp=1", valid_d); end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL brst_count got=%0d exp=3", fetch_count); end
    stall_f = 0;
    step();
    pc_src_br = 0;
    checks++; if (pc_f !== 32'h80) begin errors++; $display("FAIL br_pc got=%h exp=%h", pc_f, 32'h80); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL br_bubble_valid got=%b exp=0", valid_d); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL br_bubble_instr got=%h exp=%h", instr_d, 32'h0); end
    step();
    checks++; if (pc_f !== 32'h84) begin errors++; $display("FAIL br_next_pc got=%h exp=%h", pc_f, 32'h84); end
    checks++; if (instr_d !== word_at(32'h80)) begin errors++; $display("FAIL br_target_instr got=%h exp=%h", instr_d, word_at(32'h80)); end
    checks++; if (pc_plus4_d !== 32'h84) begin errors++; $display("FAIL br_target_pcp4 got=%h exp=%h", pc_plus4_d, 32'h84); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL br_target_count got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_priority_back_to_back();
    do_reset();
    step();
    jr = 1; jr_target = 32'h100; jump = 1; jump_target = 32'h200;
    step();
    checks++; if (pc_f !== 32'h100) begin errors++; $display("FAIL prio_jr_pc got=%h exp=%h", pc_f, 32'h100); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL prio_jr_valid got=%b exp=0", valid_d); end
    // second redirect while the first is still in flight: jump beats branch
    jr = 0; pc_src_br = 1; br_target = 32'h300;
    step();
    clear_inputs();
    checks++; if (pc_f !== 32'h200) begin errors++; $display("FAIL prio_jump_pc got=%h exp=%h", pc_f, 32'h200); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL b2b_valid got=%b exp=0", valid_d); end
    step();
    checks++; if (pc_f !== 32'h204) begin errors++; $display("FAIL b2b_next_pc got=%h exp=%h", pc_f, 32'h204); end
    checks++; if (instr_d !== word_at(32'h200)) begin errors++; $display("FAIL b2b_instr got=%h exp=%h", instr_d, word_at(32'h200)); end
    checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", fetch_count); end
  endtask

  task automatic test_async_reset_and_wrap();
    do_reset();
    step(); step();
    jump = 1; jump_target = 32'h40;
    step();
    jump = 0;
    checks++; if (pc_f !== 32'h40) begin errors++; $display("FAIL ar_pre_pc got=%h exp=%h", pc_f, 32'h40); end
    #2;
    rst = 1;
    #1;
    checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL ar_pc got=%h exp=%h", pc_f, 32'h0); end
    checks++; if (instr_d !== 32'h0) begin errors++; $display("FAIL ar_instr got=%h exp=%h", instr_d, 32'h0); end
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", valid_d); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL ar_count got=%0d exp=0", fetch_count); end
    checks++; if (pc_plus4_d !== 32'h0) begin errors++; $display("FAIL ar_pcp4 got=%h exp=%h", pc_plus4_d, 32'h0); end
    checks++; if (w_pc_f2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_pc got=%h exp=%h", w_pc_f2, 32'hFFFF_FFFC); end
    step();
    rst = 0;
    step();
    checks++; if (pc_f !== 32'h4) begin errors++; $display("FAIL ar_after_pc got=%h exp=%h", pc_f, 32'h4); end
    checks++; if (w_pc_f2 !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", w_pc_f2, 32'h0); end
    checks++; if (w_pc_plus4_d2 !== 32'h0) begin errors++; $display("FAIL wrap_pcp4 got=%h exp=%h", w_pc_plus4_d2, 32'h0); end
    checks++; if (w_instr_d2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr got=%h exp=%h", w_instr_d2, 32'hFFFF_FFFC); end
    checks++; if (w_fetch_count2 !== 32'd1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", w_fetch_count2); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_free_run();
    test_jump();
    test_stall();
    test_branch_stalled();
    test_priority_back_to_back();
    test_async_reset_and_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout no completion within bound");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
